// File: rtl/regfile_scoreboard_pkg.sv
// Shared configuration for the register file / scoreboard slice.
// Holds the architectural register geometry, the zero word and the enable/disable
// constants used by regfile_scoreboard and rf_busy_table. New defaults go here.
package regfile_scoreboard_pkg;

   // Architectural register geometry.
   localparam int unsigned RegAddrLen = 5;
   localparam int unsigned RegLen     = 32;
   localparam int unsigned RegNum     = 1 << RegAddrLen;

   localparam logic [RegLen-1:0] ZERO_WORD = '0;

   localparam logic Enable  = 1'b1;
   localparam logic Disable = 1'b0;

   // Scoreboard defaults.
   localparam int unsigned DefNrd  = 2;
   localparam int unsigned DefTagW = 4;

   // True when an access addresses a real (non-x0) register.
   function automatic logic addr_live(input logic valid, input logic nonzero);
      return valid & nonzero;
   endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Busy/tag scoreboard for the register file.
// One busy bit and one producer tag per register. Issue marks a register pending,
// a writeback with a matching tag releases it, flush drops every pending bit.
// Entry 0 is never marked busy.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active-low
//   we_i         writeback valid
//   waddr_i      writeback destination
//   wtag_i       tag of the writing producer
//   iss_valid_i  issue allocates a destination
//   iss_rd_i     allocated destination
//   iss_tag_i    tag of the issuing producer
//   flush_i      clear all pending state
//   busy_o       stored busy bit per entry
//   tag_o        stored tag per entry, entry i at [i*TAG_W +: TAG_W]
//   wb_bypass_o  per entry: a same-cycle writeback releases it and no issue re-claims it
//   busy_any_o   OR of all stored busy bits
module rf_busy_table
   import regfile_scoreboard_pkg::*;
#(
   parameter int unsigned NREG  = RegNum,
   parameter int unsigned TAG_W = DefTagW,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [TAG_W-1:0]      wtag_i,
   input  logic                  iss_valid_i,
   input  logic [AW-1:0]         iss_rd_i,
   input  logic [TAG_W-1:0]      iss_tag_i,
   input  logic                  flush_i,
   output logic [NREG-1:0]       busy_o,
   output logic [NREG*TAG_W-1:0] tag_o,
   output logic [NREG-1:0]       wb_bypass_o,
   output logic                  busy_any_o
);

   logic [NREG-1:0]  busy_q;
   logic [NREG-1:0]  busy_d;
   logic [TAG_W-1:0] tag_q [NREG];
   logic [TAG_W-1:0] tag_d [NREG];

   logic [NREG-1:0]  wb_hit;
   logic [NREG-1:0]  iss_hit;

   // Decode which entries a writeback releases and which an issue claims.
   always_comb begin
      wb_hit  = '0;
      iss_hit = '0;
      for (int i = 1; i < NREG; i++) begin
         wb_hit[i]  = addr_live(we_i, waddr_i == AW'(i)) & busy_q[i] & (tag_q[i] == wtag_i);
         // A flush cancels any issue in the same cycle.
         iss_hit[i] = addr_live(iss_valid_i & ~flush_i, iss_rd_i == AW'(i));
      end
   end

   // Next state: flush / tag-matched release, then issue on top (issue wins).
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         tag_d[i] = tag_q[i];
         if (flush_i || wb_hit[i]) begin
            busy_d[i] = Disable;
         end
         if (iss_hit[i]) begin
            busy_d[i] = Enable;
            tag_d[i]  = iss_tag_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         busy_q <= busy_d;
         for (int i = 0; i < NREG; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         tag_o[i*TAG_W +: TAG_W] = tag_q[i];
      end
   end

   assign busy_o      = busy_q;
   assign wb_bypass_o = wb_hit & ~iss_hit;
   assign busy_any_o  = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with an attached producer scoreboard.
// NREG x XLEN data array with NRD zero-latency read ports. Each read port returns
// data (with writeback bypass), the pending bit and the pending producer tag.
// Busy/tag bookkeeping lives in rf_busy_table.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-low
//   we         writeback valid
//   waddr      writeback destination
//   wdata      writeback data
//   wtag       tag of the writing producer
//   iss_valid  issue allocates a destination
//   iss_rd     allocated destination
//   iss_tag    tag of the issuing producer
//   flush      clear all pending state
//   re         per-port read enable
//   raddr      packed read addresses, port k at [k*AW +: AW]
//   rdata      packed read data, port k at [k*XLEN +: XLEN]
//   rbusy      per-port source-pending flag
//   rtag       packed pending producer tag, port k at [k*TAG_W +: TAG_W]
//   busy_any   any register pending
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int unsigned XLEN  = RegLen,
   parameter int unsigned NREG  = RegNum,
   parameter int unsigned NRD   = DefNrd,
   parameter int unsigned TAG_W = DefTagW,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [XLEN-1:0]      wdata,
   input  logic [TAG_W-1:0]     wtag,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic [TAG_W-1:0]     iss_tag,
   input  logic                 flush,
   input  logic [NRD-1:0]       re,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*XLEN-1:0]  rdata,
   output logic [NRD-1:0]       rbusy,
   output logic [NRD*TAG_W-1:0] rtag,
   output logic                 busy_any
);

   localparam logic [XLEN-1:0] ZeroData = XLEN'(ZERO_WORD);

   logic [XLEN-1:0]       mem_q [NREG];
   logic [NREG-1:0]       busy;
   logic [NREG*TAG_W-1:0] tag_flat;
   logic [NREG-1:0]       wb_bypass;
   logic                  busy_any_raw;

   rf_busy_table #(
      .NREG  (NREG),
      .TAG_W (TAG_W)
   ) u_busy_table (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we),
      .waddr_i     (waddr),
      .wtag_i      (wtag),
      .iss_valid_i (iss_valid),
      .iss_rd_i    (iss_rd),
      .iss_tag_i   (iss_tag),
      .flush_i     (flush),
      .busy_o      (busy),
      .tag_o       (tag_flat),
      .wb_bypass_o (wb_bypass),
      .busy_any_o  (busy_any_raw)
   );

   // Data array; x0 is never written so it stays at its reset value of zero.
   // Writeback data lands even during a flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= ZeroData;
         end
      end else if (addr_live(we, waddr != '0)) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read ports. Same-cycle issues are deliberately invisible here.
   always_comb begin
      rdata = '0;
      rbusy = '0;
      rtag  = '0;
      for (int k = 0; k < NRD; k++) begin
         logic [AW-1:0] a;
         a = raddr[k*AW +: AW];
         if (rst && addr_live(re[k], a != '0)) begin
            rdata[k*XLEN +: XLEN] = (we && waddr == a) ? wdata : mem_q[a];
            rbusy[k]              = busy[a] & ~wb_bypass[a];
            if (rbusy[k]) begin
               rtag[k*TAG_W +: TAG_W] = tag_flat[int'(a)*TAG_W +: TAG_W];
            end
         end
      end
   end

   assign busy_any = rst & busy_any_raw;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (NRD=4): directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned NRD   = 4;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned AW    = $clog2(NREG);

   logic                 clk;
   logic                 rst;
   logic                 we;
   logic [AW-1:0]        waddr;
   logic [XLEN-1:0]      wdata;
   logic [TAG_W-1:0]     wtag;
   logic                 iss_valid;
   logic [AW-1:0]        iss_rd;
   logic [TAG_W-1:0]     iss_tag;
   logic                 flush;
   logic [NRD-1:0]       re;
   logic [NRD*AW-1:0]    raddr;
   logic [NRD*XLEN-1:0]  rdata;
   logic [NRD-1:0]       rbusy;
   logic [NRD*TAG_W-1:0] rtag;
   logic                 busy_any;

   regfile_scoreboard #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .NRD   (NRD),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .wtag      (wtag),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_tag   (iss_tag),
      .flush     (flush),
      .re        (re),
      .raddr     (raddr),
      .rdata     (rdata),
      .rbusy     (rbusy),
      .rtag      (rtag),
      .busy_any  (busy_any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model: architectural contents of each register.
   logic [XLEN-1:0]  m_data [NREG];
   logic             m_busy [NREG];
   logic [TAG_W-1:0] m_tag  [NREG];

   // Stimulus for the current cycle.
   logic             s_rst;
   logic             s_we;
   logic [AW-1:0]    s_waddr;
   logic [XLEN-1:0]  s_wdata;
   logic [TAG_W-1:0] s_wtag;
   logic             s_iv;
   logic [AW-1:0]    s_ird;
   logic [TAG_W-1:0] s_itag;
   logic             s_flush;
   logic [NRD-1:0]   s_re;
   logic [AW-1:0]    s_raddr [NRD];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      s_rst   = 1'b1;
      s_we    = 1'b0;
      s_waddr = '0;
      s_wdata = '0;
      s_wtag  = '0;
      s_iv    = 1'b0;
      s_ird   = '0;
      s_itag  = '0;
      s_flush = 1'b0;
      s_re    = '1;
      for (int k = 0; k < NRD; k++) s_raddr[k] = '0;
   endtask

   // Apply stimulus, let it settle, compare every read port against the model.
   task automatic settle();
      logic             busy_seen;
      logic [AW-1:0]    a;
      logic [XLEN-1:0]  e_d;
      logic             e_b;
      logic [TAG_W-1:0] e_t;
      logic             released;
      logic             reclaimed;
      rst       = s_rst;
      we        = s_we;
      waddr     = s_waddr;
      wdata     = s_wdata;
      wtag      = s_wtag;
      iss_valid = s_iv;
      iss_rd    = s_ird;
      iss_tag   = s_itag;
      flush     = s_flush;
      re        = s_re;
      for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = s_raddr[k];
      #4;
      for (int k = 0; k < NRD; k++) begin
         a   = s_raddr[k];
         e_d = '0;
         e_b = 1'b0;
         e_t = '0;
         if (s_rst && s_re[k] && a != 0) begin
            e_d       = (s_we && s_waddr == a) ? s_wdata : m_data[a];
            released  = s_we && s_waddr == a && m_busy[a] && m_tag[a] == s_wtag;
            reclaimed = s_iv && !s_flush && s_ird == a;
            e_b       = (released && !reclaimed) ? 1'b0 : m_busy[a];
            e_t       = e_b ? m_tag[a] : '0;
         end
         check($sformatf("rdata%0d", k), 64'(rdata[k*XLEN +: XLEN]), 64'(e_d));
         check($sformatf("rbusy%0d", k), 64'(rbusy[k]), 64'(e_b));
         check($sformatf("rtag%0d", k), 64'(rtag[k*TAG_W +: TAG_W]), 64'(e_t));
      end
      busy_seen = 1'b0;
      for (int i = 0; i < NREG; i++) busy_seen = busy_seen | m_busy[i];
      check("busy_any", 64'(busy_any), 64'(s_rst & busy_seen));
   endtask

   // Clock edge: advance the model with the same stimulus the DUT sampled.
   task automatic tick();
      int w;
      @(posedge clk);
      if (!s_rst) begin
         for (int i = 0; i < NREG; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
         end
      end else begin
         if (s_we && s_waddr != 0) begin
            w = int'(s_waddr);
            if (m_busy[w] && m_tag[w] == s_wtag) m_busy[w] = 1'b0;
            m_data[w] = s_wdata;
         end
         if (s_flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
         end else if (s_iv && s_ird != 0) begin
            m_busy[s_ird] = 1'b1;
            m_tag[s_ird]  = s_itag;
         end
      end
      #1;
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NREG; i++) begin
         m_data[i] = '0;
         m_busy[i] = 1'b0;
         m_tag[i]  = '0;
      end
      idle();
      @(posedge clk);
      #1;

      // Reset state.
      s_rst = 1'b0;
      cycle();
      cycle();
      idle();
      s_raddr[0] = 5'd5;
      s_raddr[1] = 5'd31;
      settle();
      check("rst_rdata", 64'(rdata[0 +: XLEN]), 64'h0);
      check("rst_busy_any", 64'(busy_any), 64'h0);
      tick();

      // Issue x5 tag 3, then read it pending; then release with matching tag.
      idle(); s_iv = 1'b1; s_ird = 5'd5; s_itag = 4'd3;
      cycle();
      idle(); s_raddr[0] = 5'd5;
      settle();
      check("iss5_busy", 64'(rbusy[0]), 64'h1);
      check("iss5_tag", 64'(rtag[0 +: TAG_W]), 64'h3);
      tick();
      idle(); s_we = 1'b1; s_waddr = 5'd5; s_wtag = 4'd3; s_wdata = 32'hDEAD_BEEF;
      s_raddr[0] = 5'd5;
      settle();
      check("wb5_bypass_data", 64'(rdata[0 +: XLEN]), 64'hDEAD_BEEF);
      check("wb5_bypass_busy", 64'(rbusy[0]), 64'h0);
      tick();

      // Older producer writes back after a newer one claimed x7.
      idle(); s_iv = 1'b1; s_ird = 5'd7; s_itag = 4'd1;
      cycle();
      idle(); s_iv = 1'b1; s_ird = 5'd7; s_itag = 4'd2;
      cycle();
      idle(); s_we = 1'b1; s_waddr = 5'd7; s_wtag = 4'd1; s_wdata = 32'h11;
      cycle();
      idle(); s_raddr[1] = 5'd7;
      settle();
      check("x7_data", 64'(rdata[XLEN +: XLEN]), 64'h11);
      check("x7_busy", 64'(rbusy[1]), 64'h1);
      check("x7_tag", 64'(rtag[TAG_W +: TAG_W]), 64'h2);
      tick();

      // Issue and writeback to x9 in the same cycle: issue wins.
      idle(); s_iv = 1'b1; s_ird = 5'd9; s_itag = 4'd4;
      s_we = 1'b1; s_waddr = 5'd9; s_wtag = 4'd4; s_wdata = 32'h22;
      cycle();
      idle(); s_raddr[2] = 5'd9;
      settle();
      check("x9_data", 64'(rdata[2*XLEN +: XLEN]), 64'h22);
      check("x9_busy", 64'(rbusy[2]), 64'h1);
      check("x9_tag", 64'(rtag[2*TAG_W +: TAG_W]), 64'h4);
      tick();

      // x1..x3 busy, then flush with a coincident writeback to x2.
      for (int r = 1; r <= 3; r++) begin
         idle(); s_iv = 1'b1; s_ird = AW'(r); s_itag = 4'(r + 8);
         cycle();
      end
      idle(); s_flush = 1'b1; s_we = 1'b1; s_waddr = 5'd2; s_wtag = 4'd0; s_wdata = 32'h33;
      cycle();
      idle(); s_raddr[0] = 5'd2;
      settle();
      check("flush_busy_any", 64'(busy_any), 64'h0);
      check("flush_x2_data", 64'(rdata[0 +: XLEN]), 64'h33);
      tick();
      // Issue coincident with flush is dropped.
      idle(); s_flush = 1'b1; s_iv = 1'b1; s_ird = 5'd6; s_itag = 4'd7;
      cycle();
      idle(); s_raddr[0] = 5'd6;
      settle();
      check("flush_iss_dropped", 64'(rbusy[0]), 64'h0);
      tick();

      // x0 ignores writes and issues.
      idle(); s_we = 1'b1; s_waddr = 5'd0; s_wdata = 32'hFFFF; s_iv = 1'b1; s_ird = 5'd0;
      s_itag = 4'd5;
      cycle();
      idle();
      settle();
      check("x0_data", 64'(rdata[0 +: XLEN]), 64'h0);
      check("x0_busy", 64'(rbusy[0]), 64'h0);
      tick();

      // All four ports on distinct registers.
      idle();
      s_raddr[0] = 5'd5; s_raddr[1] = 5'd7; s_raddr[2] = 5'd9; s_raddr[3] = 5'd2;
      settle();
      check("p0_x5", 64'(rdata[0 +: XLEN]), 64'hDEAD_BEEF);
      check("p1_x7", 64'(rdata[XLEN +: XLEN]), 64'h11);
      check("p2_x9", 64'(rdata[2*XLEN +: XLEN]), 64'h22);
      check("p3_x2", 64'(rdata[3*XLEN +: XLEN]), 64'h33);
      tick();

      // Reset while x4 is pending with data.
      idle(); s_we = 1'b1; s_waddr = 5'd4; s_wdata = 32'h44;
      cycle();
      idle(); s_iv = 1'b1; s_ird = 5'd4; s_itag = 4'd5;
      cycle();
      idle(); s_rst = 1'b0; s_raddr[0] = 5'd4;
      s_we = 1'b1; s_waddr = 5'd4; s_wdata = 32'h55; s_iv = 1'b1; s_ird = 5'd8;
      settle();
      check("inrst_data", 64'(rdata[0 +: XLEN]), 64'h0);
      check("inrst_busy", 64'(rbusy[0]), 64'h0);
      check("inrst_busy_any", 64'(busy_any), 64'h0);
      tick();
      idle(); s_raddr[0] = 5'd4; s_raddr[1] = 5'd8;
      settle();
      check("postrst_x4_data", 64'(rdata[0 +: XLEN]), 64'h0);
      check("postrst_x4_busy", 64'(rbusy[0]), 64'h0);
      check("postrst_busy_any", 64'(busy_any), 64'h0);
      tick();

      // Randomized traffic on a small register window to force collisions.
      for (int c = 0; c < 3000; c++) begin
         idle();
         s_rst   = ($urandom_range(63) != 0);
         s_flush = ($urandom_range(15) == 0);
         s_we    = ($urandom_range(1) == 1);
         s_waddr = AW'($urandom_range(7));
         s_wdata = $urandom;
         s_wtag  = TAG_W'($urandom_range(3));
         s_iv    = !s_flush && ($urandom_range(2) != 0);
         s_ird   = AW'($urandom_range(7));
         s_itag  = TAG_W'($urandom_range(3));
         s_re    = NRD'($urandom_range(15));
         for (int k = 0; k < NRD; k++) begin
            case ($urandom_range(3))
               0:       s_raddr[k] = s_waddr;
               1:       s_raddr[k] = s_ird;
               default: s_raddr[k] = AW'($urandom_range(NREG - 1));
            endcase
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
